// File: rtl/update_y_writer.sv
// Copies NUM_Y result-buffer words into Y SRAM starting at a latched base address.
// Build option Y_WRITE_SAT_EN: saturate (instead of truncate) result data to DATA_W.
module update_y_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NUM_Y  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_writeYvalEnable,
  input  logic [ADDR_W-1:0] in_yBaseAddr,
  output logic [ADDR_W-1:0] op_resultRdAddr,
  input  logic [DATA_W+3:0] in_resultRdData,
  output logic [ADDR_W-1:0] op_ySramAddr,
  output logic [DATA_W-1:0] op_ySramWrData,
  output logic              op_ySramWrEn,
  output logic              op_updateYwriteDoneFlag,
  output logic [2:0]        op_dbgState
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WRITE   = 3'd2,
    S_DONE    = 3'd3,
    S_WAITLOW = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_Y - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic [ADDR_W-1:0] r_wrCnt, w_wrCnt_nxt;
  logic [ADDR_W-1:0] r_rdAddr, w_rdAddr_nxt;
  logic [ADDR_W-1:0] r_ySramAddr, w_ySramAddr_nxt;
  logic [DATA_W-1:0] r_wrData, w_wrData_nxt;
  logic              r_wrEn, w_wrEn_nxt;
  logic              r_done, w_done_nxt;
  logic [DATA_W-1:0] w_narrow;
  logic              w_en;

  assign w_en = in_writeYvalEnable;

`ifdef Y_WRITE_SAT_EN
  logic [4:0] w_upper;
  assign w_upper = in_resultRdData[DATA_W+3:DATA_W-1];
  always_comb begin
    // In range only when the top five bits are all sign copies.
    if ((&w_upper) || !(|w_upper))
      w_narrow = in_resultRdData[DATA_W-1:0];
    else if (w_upper[4])
      w_narrow = {1'b1, {(DATA_W-1){1'b0}}};
    else
      w_narrow = {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^in_resultRdData[DATA_W+3:DATA_W];
  assign w_narrow    = in_resultRdData[DATA_W-1:0];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_wrCnt     <= '0;
      r_rdAddr    <= '0;
      r_ySramAddr <= '0;
      r_wrData    <= '0;
      r_wrEn      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_base      <= w_base_nxt;
      r_wrCnt     <= w_wrCnt_nxt;
      r_rdAddr    <= w_rdAddr_nxt;
      r_ySramAddr <= w_ySramAddr_nxt;
      r_wrData    <= w_wrData_nxt;
      r_wrEn      <= w_wrEn_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_en) w_next = S_READ;
      S_READ:    w_next = w_en ? S_WRITE : S_IDLE;
      S_WRITE: begin
        if (!w_en)                 w_next = S_IDLE;
        else if (r_wrCnt == LAST_K) w_next = S_DONE;
      end
      S_DONE:    w_next = S_WAITLOW;
      S_WAITLOW: if (!w_en) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Read address runs one ahead of the write counter so read data lines up with each write.
  always_comb begin
    w_base_nxt      = r_base;
    w_wrCnt_nxt     = r_wrCnt;
    w_rdAddr_nxt    = r_rdAddr;
    w_ySramAddr_nxt = r_ySramAddr;
    w_wrData_nxt    = r_wrData;
    w_wrEn_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_en) begin
          w_base_nxt   = in_yBaseAddr;
          w_rdAddr_nxt = '0;
          w_wrCnt_nxt  = '0;
        end
      end
      S_READ: begin
        if (w_en) w_rdAddr_nxt = r_rdAddr + 1'b1;
      end
      S_WRITE: begin
        if (w_en) begin
          w_wrEn_nxt      = 1'b1;
          w_ySramAddr_nxt = r_base + r_wrCnt;
          w_wrData_nxt    = w_narrow;
          w_wrCnt_nxt     = r_wrCnt + 1'b1;
          w_rdAddr_nxt    = r_rdAddr + 1'b1;
        end
      end
      S_DONE:  w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  assign op_resultRdAddr         = r_rdAddr;
  assign op_ySramAddr            = r_ySramAddr;
  assign op_ySramWrData          = r_wrData;
  assign op_ySramWrEn            = r_wrEn;
  assign op_updateYwriteDoneFlag = r_done;
  assign op_dbgState             = r_state;

endmodule

// File: tb/tb_update_y_writer.sv
// Directed bench for update_y_writer: reference write list per burst, cycle-by-cycle compare.
module tb_update_y_writer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int NUM_Y  = 16;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAITLOW = 3'd4;

  logic              clock = 1'b0;
  logic              reset;
  logic              en;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W+3:0] rd_data;
  logic [ADDR_W-1:0] y_addr;
  logic [DATA_W-1:0] y_data;
  logic              wr_en;
  logic              done;
  logic [2:0]        dbg;

  update_y_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_Y(NUM_Y)) dut (
    .clock(clock), .reset(reset), .in_writeYvalEnable(en), .in_yBaseAddr(base),
    .op_resultRdAddr(rd_addr), .in_resultRdData(rd_data), .op_ySramAddr(y_addr),
    .op_ySramWrData(y_data), .op_ySramWrEn(wr_en), .op_updateYwriteDoneFlag(done),
    .op_dbgState(dbg)
  );

  always #5 clock = ~clock;

  logic [DATA_W+3:0] mem [256];
  logic [ADDR_W+DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] log_addr [$];
  logic [DATA_W-1:0] log_data [$];
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  int total = 0, bad = 0;
  int cyc = 0, burst_writes = 0, done_cnt = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0, t0 = 0;

`ifdef Y_WRITE_SAT_EN
  localparam logic [15:0] EXP_12345 = 16'h7FFF;
`else
  localparam logic [15:0] EXP_12345 = 16'h2345;
`endif

  // Synchronous result buffer: data for an address appears one cycle later.
  always @(posedge clock) begin
    rd_data <= mem[rd_addr];
    cyc     <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] nar(input logic [19:0] d);
    int v;
    v = int'($signed(d));
`ifdef Y_WRITE_SAT_EN
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
`else
    return d[15:0];
`endif
  endfunction

  always @(negedge clock) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (!reset) begin
      last_addr = '0;
      last_data = '0;
    end else begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("write_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", y_addr, e[ADDR_W+DATA_W-1:DATA_W]);
          chk("wr_data", y_data, e[DATA_W-1:0]);
          last_addr = e[ADDR_W+DATA_W-1:DATA_W];
          last_data = e[DATA_W-1:0];
        end
        if (burst_writes == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        burst_writes++;
        log_addr.push_back(y_addr);
        log_data.push_back(y_data);
      end else begin
        chk("hold_addr", y_addr, last_addr);
        chk("hold_data", y_data, last_data);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_wren_low", wr_en, 0);
      end
    end
  end

  task automatic load_burst(input logic [ADDR_W-1:0] b);
    logic [ADDR_W-1:0] a;
    exp_q.delete();
    log_addr.delete();
    log_data.delete();
    burst_writes = 0;
    done_cnt = 0;
    for (int k = 0; k < NUM_Y; k++) begin
      a = b + ADDR_W'(k);
      exp_q.push_back({a, nar(mem[k])});
    end
  endtask

  task automatic run_burst(input logic [ADDR_W-1:0] b, input int hold);
    load_burst(b);
    @(negedge clock);
    base = b;
    en = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin
      @(negedge clock); #1;
    end
    chk("done_seen", (done_cnt > 0) ? 1 : 0, 1);
    chk("first_write_latency", first_wr_cyc - t0, 2);
    chk("done_after_last_write", done_cyc - last_wr_cyc, 1);
    chk("write_count", burst_writes, NUM_Y);
    chk("exp_left", exp_q.size(), 0);
    chk("state_waitlow", dbg, ST_WAITLOW);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock); #1;
      chk("state_waitlow_hold", dbg, ST_WAITLOW);
    end
    en = 1'b0;
    @(posedge clock); #1;
    chk("state_idle_after", dbg, ST_IDLE);
    repeat (3) @(negedge clock);
    #1;
    chk("one_burst_writes", burst_writes, NUM_Y);
    chk("one_done_pulse", done_cnt, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 20'(i * 20'h00101 + 20'h00011);
    mem[0] = 20'h12345;
    mem[1] = 20'hF8000;
    mem[2] = 20'h80000;
    mem[3] = 20'h07FFF;
    mem[4] = 20'hFFFFF;
    reset = 1'b0;
    en = 1'b0;
    base = '0;
    #1;
    chk("rst_wren", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_yaddr", y_addr, 0);
    chk("rst_ydata", y_data, 0);
    chk("rst_rdaddr", rd_addr, 0);
    chk("rst_state", dbg, ST_IDLE);
    chk("pin_model_12345", nar(20'h12345), EXP_12345);
    chk("pin_model_f8000", nar(20'hF8000), 16'h8000);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Basic burst at 0x10.
    run_burst(8'h10, 0);
    chk("b1_first_addr", log_addr[0], 8'h10);
    chk("b1_last_addr", log_addr[NUM_Y-1], 8'h1F);
    chk("b1_word0_data", log_data[0], EXP_12345);
    chk("b1_word1_data", log_data[1], 16'h8000);

    // Wrapping burst with enable held after done.
    run_burst(8'hF8, 10);
    chk("b2_addr0", log_addr[0], 8'hF8);
    chk("b2_addr7", log_addr[7], 8'hFF);
    chk("b2_addr8", log_addr[8], 8'h00);
    chk("b2_addr15", log_addr[NUM_Y-1], 8'h07);

    // Abort after five writes.
    load_burst(8'h30);
    @(negedge clock);
    base = 8'h30;
    en = 1'b1;
    for (int i = 0; i < 50 && burst_writes < 5; i++) begin
      @(negedge clock); #1;
    end
    en = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("abort_writes", burst_writes, 5);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_state", dbg, ST_IDLE);
    chk("abort_exp_left", exp_q.size(), NUM_Y - 5);

    // Asynchronous reset mid-burst.
    load_burst(8'h50);
    @(negedge clock);
    base = 8'h50;
    en = 1'b1;
    for (int i = 0; i < 50 && burst_writes < 3; i++) begin
      @(negedge clock); #1;
    end
    chk("rst_mid_was_writing", wr_en, 1);
    #2;
    reset = 1'b0;
    en = 1'b0;
    #1;
    chk("rst_mid_wren", wr_en, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_state", dbg, ST_IDLE);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_writes", burst_writes, 3);

    run_burst(8'h40, 0);
    chk("b4_first_addr", log_addr[0], 8'h40);
    chk("b4_word0_data", log_data[0], EXP_12345);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
